// File: rtl/udma_eth_rx_ring_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udma_eth_rx_ring_pkg
// Description : Register map, descriptor status bit positions and FSM states
//               shared by the uDMA Ethernet RX descriptor-ring manager.
// Revision    : 1.0 - initial release
// ============================================================================
package udma_eth_rx_ring_pkg;

    localparam logic [5:0] c_addr_ctrl     = 6'd32;
    localparam logic [5:0] c_addr_status   = 6'd33;
    localparam logic [5:0] c_addr_irq_cfg  = 6'd34;
    localparam logic [5:0] c_addr_irq_stat = 6'd35;
    localparam logic [5:0] c_addr_drop_cnt = 6'd36;

    // Upper address bits select the descriptor address / status windows.
    localparam logic [1:0] c_region_desc_addr = 2'b00;
    localparam logic [1:0] c_region_desc_stat = 2'b01;

    localparam int c_own_bit   = 31;
    localparam int c_err_bit   = 30;
    localparam int c_trunc_bit = 29;

    localparam int c_ctrl_en_bit  = 0;
    localparam int c_ctrl_clr_bit = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_WAIT = 2'd2
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/udma_eth_irq_coalesce.sv
`default_nettype none
// ============================================================================
// Module      : udma_eth_irq_coalesce
// Description : Completion counter and idle timer that raise rx_pend once
//               enough frames or enough time has accumulated.
// Revision    : 1.0 - initial release
// ============================================================================
module udma_eth_irq_coalesce #(
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    input  logic             i_w1c,
    input  logic [7:0]       i_thresh,
    input  logic [TMO_W-1:0] i_timeout,
    output logic             o_rx_pend
);

    logic [7:0]       r_count;
    logic [7:0]       w_count_nxt;
    logic [TMO_W-1:0] r_timer;
    logic [TMO_W-1:0] w_timer_nxt;
    logic [7:0]       w_thr_eff;
    logic             w_set;
    logic             r_rx_pend;

    always_comb begin
        w_thr_eff   = (i_thresh == 8'd0) ? 8'd1 : i_thresh;
        w_count_nxt = r_count;
        if (i_clr) begin
            w_count_nxt = 8'd0;
        end else if (i_w1c) begin
            w_count_nxt = {7'd0, i_inc};
        end else if (i_inc && (r_count != 8'hFF)) begin
            w_count_nxt = r_count + 8'd1;
        end
        w_timer_nxt = r_timer;
        if (i_clr || i_w1c) begin
            w_timer_nxt = '0;
        end else if ((r_count != 8'd0) && (r_timer != {TMO_W{1'b1}})) begin
            w_timer_nxt = r_timer + 1'b1;
        end
        // Evaluated on next-state values so a W1C only loses to a genuine new event.
        w_set = (w_count_nxt >= w_thr_eff) ||
                ((i_timeout != '0) && (w_count_nxt != 8'd0) && (w_timer_nxt >= i_timeout));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= 8'd0;
            r_timer   <= '0;
            r_rx_pend <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_timer   <= w_timer_nxt;
            r_rx_pend <= w_set | (r_rx_pend & ~i_w1c);
        end
    end

    assign o_rx_pend = r_rx_pend;

endmodule
`default_nettype wire

// File: rtl/udma_eth_rx_ring.sv
`default_nettype none
// ============================================================================
// Module      : udma_eth_rx_ring
// Description : N-slot RX descriptor ring with HW/SW ownership, uDMA arming
//               FSM, drop counting, truncation detection and coalesced IRQs.
// Revision    : 1.0 - initial release
// ============================================================================
module udma_eth_rx_ring
    import udma_eth_rx_ring_pkg::*;
#(
    parameter int N_DESC         = 4,
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int TMO_W          = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [31:0]                 cfg_data_i,
    input  logic [5:0]                  cfg_addr_i,
    input  logic                        cfg_valid_i,
    input  logic                        cfg_rwn_i,
    output logic [31:0]                 cfg_data_o,
    output logic                        cfg_ready_o,
    output logic [L2_AWIDTH_NOAL-1:0]   ch_startaddr_o,
    output logic [TRANS_SIZE-1:0]       ch_size_o,
    output logic                        ch_en_o,
    output logic                        ch_clr_o,
    input  logic                        frame_done_i,
    input  logic [TRANS_SIZE-1:0]       frame_len_i,
    input  logic                        frame_err_i,
    output logic                        rx_ready_o,
    output logic [$clog2(N_DESC)-1:0]   head_idx_o,
    output logic                        irq_o
);

    localparam int HEAD_W = $clog2(N_DESC);

    logic [L2_AWIDTH_NOAL-1:0] r_desc_addr [N_DESC];
    logic [TRANS_SIZE-1:0]     r_desc_len  [N_DESC];
    logic [N_DESC-1:0]         r_desc_own;
    logic [N_DESC-1:0]         r_desc_err;
    logic [N_DESC-1:0]         r_desc_trunc;

    rx_state_e          r_state;
    rx_state_e          w_state_nxt;
    logic [HEAD_W-1:0]  r_head;
    logic               r_en;
    logic [15:0]        r_drop_cnt;
    logic               r_err;
    logic               r_rx_irq_en;
    logic               r_err_irq_en;
    logic [7:0]         r_thresh;
    logic [TMO_W-1:0]   r_timeout;
    logic               r_irq;
    logic               r_ch_clr;
    logic               w_rx_pend;

    logic               w_wr, w_rd, w_idx_ok, w_addr_sel, w_stat_sel;
    logic [HEAD_W-1:0]  w_idx;
    logic               w_ctrl_wr, w_clr, w_ctrl_stop, w_abort;
    logic               w_done, w_drop, w_trunc;
    logic [TRANS_SIZE-1:0] w_len;
    logic               w_irqs_wr, w_pend_w1c, w_drop_rd, w_err_set;
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign w_wr       = cfg_valid_i & ~cfg_rwn_i;
    assign w_rd       = cfg_valid_i & cfg_rwn_i;
    assign w_idx      = cfg_addr_i[HEAD_W-1:0];
    assign w_idx_ok   = ({1'b0, cfg_addr_i[3:0]} < 5'(N_DESC));
    assign w_addr_sel = (cfg_addr_i[5:4] == c_region_desc_addr) && w_idx_ok;
    assign w_stat_sel = (cfg_addr_i[5:4] == c_region_desc_stat) && w_idx_ok;
    assign w_ctrl_wr  = w_wr && (cfg_addr_i == c_addr_ctrl);
    assign w_clr      = w_ctrl_wr && cfg_data_i[c_ctrl_clr_bit];
    // Any CTRL write that drops en or requests clr stops an in-flight buffer.
    assign w_ctrl_stop = w_ctrl_wr && (!cfg_data_i[c_ctrl_en_bit] || cfg_data_i[c_ctrl_clr_bit]);
    assign w_abort    = w_ctrl_stop && (r_state != ST_IDLE);
    assign w_done     = frame_done_i && (r_state == ST_WAIT);
    assign w_drop     = frame_done_i && (r_state != ST_WAIT);
    assign w_trunc    = frame_len_i > r_desc_len[r_head];
    assign w_len      = w_trunc ? r_desc_len[r_head] : frame_len_i;
    assign w_irqs_wr  = w_wr && (cfg_addr_i == c_addr_irq_stat);
    assign w_pend_w1c = w_irqs_wr && cfg_data_i[0];
    assign w_drop_rd  = w_rd && (cfg_addr_i == c_addr_drop_cnt);
    assign w_err_set  = w_drop || (w_done && frame_err_i);
    assign w_unused   = ^cfg_data_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (r_en && r_desc_own[r_head] && !w_ctrl_stop) w_state_nxt = ST_ARM;
            ST_ARM:  w_state_nxt = ST_WAIT;
            ST_WAIT: if (w_done) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_abort) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_DESC; i++) begin
                r_desc_addr[i] <= '0;
                r_desc_len[i]  <= '0;
            end
            r_desc_own   <= '0;
            r_desc_err   <= '0;
            r_desc_trunc <= '0;
        end else begin
            if (w_wr && w_addr_sel) r_desc_addr[w_idx] <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
            // Hardware write-back owns the head slot for this cycle.
            if (w_wr && w_stat_sel && !(w_done && (w_idx == r_head))) begin
                r_desc_own[w_idx]   <= 1'b1;
                r_desc_err[w_idx]   <= 1'b0;
                r_desc_trunc[w_idx] <= 1'b0;
                r_desc_len[w_idx]   <= cfg_data_i[TRANS_SIZE-1:0];
            end
            if (w_done) begin
                r_desc_own[r_head]   <= 1'b0;
                r_desc_err[r_head]   <= frame_err_i;
                r_desc_trunc[r_head] <= w_trunc;
                r_desc_len[r_head]   <= w_len;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_en         <= 1'b0;
            r_head       <= '0;
            r_drop_cnt   <= 16'd0;
            r_err        <= 1'b0;
            r_rx_irq_en  <= 1'b0;
            r_err_irq_en <= 1'b0;
            r_thresh     <= 8'd0;
            r_timeout    <= '0;
            r_irq        <= 1'b0;
            r_ch_clr     <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_en <= cfg_data_i[c_ctrl_en_bit];
            if (w_clr)       r_head <= '0;
            else if (w_done) r_head <= r_head + 1'b1;
            if (w_clr)                             r_drop_cnt <= 16'd0;
            else if (w_drop_rd)                    r_drop_cnt <= {15'd0, w_drop};
            else if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
            r_err <= w_err_set | (r_err & ~(w_irqs_wr & cfg_data_i[1]));
            if (w_irqs_wr) begin
                r_rx_irq_en  <= cfg_data_i[8];
                r_err_irq_en <= cfg_data_i[9];
            end
            if (w_wr && (cfg_addr_i == c_addr_irq_cfg)) begin
                r_thresh  <= cfg_data_i[7:0];
                r_timeout <= cfg_data_i[8 +: TMO_W];
            end
            r_irq    <= (w_rx_pend & r_rx_irq_en) | (r_err & r_err_irq_en);
            r_ch_clr <= w_abort;
        end
    end

    udma_eth_irq_coalesce #(
        .TMO_W (TMO_W)
    ) u_coalesce (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_inc     (w_done),
        .i_clr     (w_clr),
        .i_w1c     (w_pend_w1c),
        .i_thresh  (r_thresh),
        .i_timeout (r_timeout),
        .o_rx_pend (w_rx_pend)
    );

    always_comb begin
        w_rdata = 32'd0;
        if (w_addr_sel) begin
            w_rdata[L2_AWIDTH_NOAL-1:0] = r_desc_addr[w_idx];
        end else if (w_stat_sel) begin
            w_rdata[c_own_bit]        = r_desc_own[w_idx];
            w_rdata[c_err_bit]        = r_desc_err[w_idx];
            w_rdata[c_trunc_bit]      = r_desc_trunc[w_idx];
            w_rdata[TRANS_SIZE-1:0]   = r_desc_len[w_idx];
        end else begin
            case (cfg_addr_i)
                c_addr_ctrl:     w_rdata[c_ctrl_en_bit] = r_en;
                c_addr_status: begin
                    w_rdata[8]          = (r_state != ST_IDLE);
                    w_rdata[4 +: HEAD_W] = r_head;
                    w_rdata[1:0]        = r_state;
                end
                c_addr_irq_cfg: begin
                    w_rdata[7:0]        = r_thresh;
                    w_rdata[8 +: TMO_W] = r_timeout;
                end
                c_addr_irq_stat: begin
                    w_rdata[0] = w_rx_pend;
                    w_rdata[1] = r_err;
                    w_rdata[8] = r_rx_irq_en;
                    w_rdata[9] = r_err_irq_en;
                end
                c_addr_drop_cnt: w_rdata[15:0] = r_drop_cnt;
                default:         w_rdata = 32'd0;
            endcase
        end
    end

    assign cfg_data_o     = w_rdata;
    assign cfg_ready_o    = 1'b1;
    assign ch_startaddr_o = r_desc_addr[r_head];
    assign ch_size_o      = r_desc_len[r_head];
    assign ch_en_o        = (r_state == ST_ARM);
    assign rx_ready_o     = (r_state == ST_WAIT);
    assign ch_clr_o       = r_ch_clr;
    assign head_idx_o     = r_head;
    assign irq_o          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_udma_eth_rx_ring.sv
`default_nettype none
// ============================================================================
// Module      : tb_udma_eth_rx_ring
// Description : Scoreboard bench for the RX descriptor-ring manager.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udma_eth_rx_ring;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] cfg_data_i;
    logic [5:0]  cfg_addr_i;
    logic        cfg_valid_i;
    logic        cfg_rwn_i;
    logic [31:0] cfg_data_o;
    logic        cfg_ready_o;
    logic [11:0] ch_startaddr_o;
    logic [15:0] ch_size_o;
    logic        ch_en_o;
    logic        ch_clr_o;
    logic        frame_done_i;
    logic [15:0] frame_len_i;
    logic        frame_err_i;
    logic        rx_ready_o;
    logic [1:0]  head_idx_o;
    logic        irq_o;

    always #5 clk = ~clk;

    udma_eth_rx_ring #(
        .N_DESC(4), .L2_AWIDTH_NOAL(12), .TRANS_SIZE(16), .TMO_W(16)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i), .cfg_valid_i(cfg_valid_i),
        .cfg_rwn_i(cfg_rwn_i), .cfg_data_o(cfg_data_o), .cfg_ready_o(cfg_ready_o),
        .ch_startaddr_o(ch_startaddr_o), .ch_size_o(ch_size_o), .ch_en_o(ch_en_o),
        .ch_clr_o(ch_clr_o), .frame_done_i(frame_done_i), .frame_len_i(frame_len_i),
        .frame_err_i(frame_err_i), .rx_ready_o(rx_ready_o), .head_idx_o(head_idx_o),
        .irq_o(irq_o)
    );

    int n_checks = 0;
    int n_fail = 0;
    int clr_pulses = 0;
    logic [27:0] arm_exp [$];
    logic [31:0] stat_exp [$];
    logic [27:0] mon_exp;

    // Arm scoreboard: every ch_en_o pulse is matched against the next expected slot.
    always @(negedge clk) begin
        if (ch_en_o === 1'b1) begin
            n_checks++;
            if (arm_exp.size() == 0) begin
                n_fail++;
                $display("FAIL arm_unexpected: got addr=%h size=%h, required no arm", ch_startaddr_o, ch_size_o);
            end else begin
                mon_exp = arm_exp.pop_front();
                if ({ch_startaddr_o, ch_size_o} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL arm_desc: got %h, required %h", {ch_startaddr_o, ch_size_o}, mon_exp);
                end
            end
        end
        if (ch_clr_o === 1'b1) clr_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic cfg_write(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = a; cfg_data_i = d;
        @(negedge clk);
        cfg_valid_i = 1'b0;
    endtask

    task automatic cfg_read(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        cfg_valid_i = 1'b1; cfg_rwn_i = 1'b1; cfg_addr_i = a;
        #1 d = cfg_data_o;
        @(negedge clk);
        cfg_valid_i = 1'b0; cfg_rwn_i = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] len, input logic err);
        @(negedge clk);
        frame_done_i = 1'b1; frame_len_i = len; frame_err_i = err;
        @(negedge clk);
        frame_done_i = 1'b0; frame_err_i = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rx_ready_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst_i = 1'b1; cfg_valid_i = 1'b0; cfg_rwn_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;
        frame_done_i = 1'b0; frame_len_i = '0; frame_err_i = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ch_en_o, ch_clr_o, rx_ready_o, irq_o, head_idx_o, ch_startaddr_o, ch_size_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {ch_en_o, ch_clr_o, rx_ready_o, irq_o, head_idx_o, ch_startaddr_o, ch_size_o});
        end
        n_checks++;
        if (cfg_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b, required 1", cfg_ready_o);
        end
        rst_i = 1'b0;
        cfg_read(6'd33, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h, required 0", rd); end
        cfg_read(6'd16, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_desc_stat: got %h, required 0", rd); end
    endtask

    task automatic test_basic_fill();
        logic [31:0] rd, e;
        bit ok;
        cfg_write(6'd0, 32'h100);
        cfg_write(6'd16, 32'h8000_0040);
        arm_exp.push_back({12'h100, 16'h0040});
        cfg_write(6'd32, 32'h1);
        @(negedge clk);
        n_checks++;
        if (ch_en_o !== 1'b1) begin n_fail++; $display("FAIL arm_latency: got ch_en=%b, required 1", ch_en_o); end
        wait_ready(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL fill_ready: got timeout, required rx_ready"); end
        stat_exp.push_back(32'h0000_003C);
        send_frame(16'h003C, 1'b0);
        cfg_read(6'd16, rd);
        e = stat_exp.pop_front();
        n_checks++;
        if (rd !== e) begin n_fail++; $display("FAIL fill_stat: got %h, required %h", rd, e); end
        n_checks++;
        if (head_idx_o !== 2'd1) begin n_fail++; $display("FAIL fill_head: got %0d, required 1", head_idx_o); end
    endtask

    task automatic test_wrap_full();
        logic [31:0] rd, e;
        bit ok;
        cfg_write(6'd32, 32'h2);
        n_checks++;
        if (head_idx_o !== 2'd0) begin n_fail++; $display("FAIL clr_head: got %0d, required 0", head_idx_o); end
        for (int i = 0; i < 4; i++) begin
            cfg_write(6'(i), 32'(12'h200 + 12'(i * 16)));
            cfg_write(6'(16 + i), 32'h8000_0000 | 32'(8'h20 + 8'(i)));
            arm_exp.push_back({12'h200 + 12'(i * 16), 16'h0020 + 16'(i)});
        end
        cfg_write(6'd32, 32'h1);
        for (int i = 0; i < 4; i++) begin
            wait_ready(ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL wrap_ready%0d: got timeout, required rx_ready", i); end
            stat_exp.push_back(32'(16'h0018 + 16'(i)));
            send_frame(16'h0018 + 16'(i), 1'b0);
            n_checks++;
            if (head_idx_o !== 2'((i + 1) % 4)) begin
                n_fail++; $display("FAIL wrap_head%0d: got %0d, required %0d", i, head_idx_o, (i + 1) % 4);
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (rx_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b, required 0", rx_ready_o); end
        send_frame(16'h0010, 1'b0);
        cfg_read(6'd36, rd);
        n_checks++;
        if (rd !== 32'd1) begin n_fail++; $display("FAIL drop_cnt: got %0d, required 1", rd); end
        cfg_read(6'd35, rd);
        n_checks++;
        if (rd[1] !== 1'b1) begin n_fail++; $display("FAIL drop_err: got %b, required 1", rd[1]); end
        cfg_read(6'd36, rd);
        n_checks++;
        if (rd !== 32'd0) begin n_fail++; $display("FAIL drop_rd_clear: got %0d, required 0", rd); end
        for (int i = 0; i < 4; i++) begin
            cfg_read(6'(16 + i), rd);
            e = stat_exp.pop_front();
            n_checks++;
            if (rd !== e) begin n_fail++; $display("FAIL wrap_stat%0d: got %h, required %h", i, rd, e); end
        end
    endtask

    task automatic test_trunc_err();
        logic [31:0] rd, e;
        bit ok;
        arm_exp.push_back({12'h200, 16'h0040});
        cfg_write(6'd16, 32'h8000_0040);
        wait_ready(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL trunc_ready: got timeout, required rx_ready"); end
        stat_exp.push_back(32'h6000_0040);
        send_frame(16'h0050, 1'b1);
        cfg_read(6'd16, rd);
        e = stat_exp.pop_front();
        n_checks++;
        if (rd !== e) begin n_fail++; $display("FAIL trunc_stat: got %h, required %h", rd, e); end
    endtask

    task automatic test_coalesce();
        bit ok;
        cfg_write(6'd34, 32'h3);
        cfg_write(6'd35, 32'h103);
        @(negedge clk);
        n_checks++;
        if (irq_o !== 1'b0) begin n_fail++; $display("FAIL coal_idle_irq: got %b, required 0", irq_o); end
        for (int i = 1; i < 4; i++) begin
            arm_exp.push_back({12'h200 + 12'(i * 16), 16'h0030});
            cfg_write(6'(16 + i), 32'h8000_0030);
        end
        for (int i = 0; i < 3; i++) begin
            wait_ready(ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL coal_ready%0d: got timeout, required rx_ready", i); end
            send_frame(16'h0020, 1'b0);
            repeat (2) @(negedge clk);
            n_checks++;
            if (irq_o !== (i == 2)) begin
                n_fail++; $display("FAIL coal_irq%0d: got %b, required %b", i, irq_o, (i == 2));
            end
        end
        cfg_write(6'd35, 32'h101);
        @(negedge clk);
        n_checks++;
        if (irq_o !== 1'b0) begin n_fail++; $display("FAIL coal_w1c: got %b, required 0", irq_o); end
    endtask

    task automatic test_timeout();
        bit ok;
        int k;
        cfg_write(6'd34, (32'd100 << 8) | 32'd8);
        arm_exp.push_back({12'h200, 16'h0040});
        cfg_write(6'd16, 32'h8000_0040);
        wait_ready(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL tmo_ready: got timeout, required rx_ready"); end
        send_frame(16'h0010, 1'b0);
        k = 0;
        for (int i = 1; i <= 150; i++) begin
            @(negedge clk);
            if (irq_o === 1'b1) begin k = i; break; end
        end
        n_checks++;
        if (k < 99 || k > 103) begin
            n_fail++; $display("FAIL tmo_irq_time: got %0d cycles, required about 101", k);
        end
        cfg_write(6'd35, 32'h101);
        @(negedge clk);
        n_checks++;
        if (irq_o !== 1'b0) begin n_fail++; $display("FAIL tmo_w1c: got %b, required 0", irq_o); end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        bit ok;
        arm_exp.push_back({12'h210, 16'h0030});
        cfg_write(6'd17, 32'h8000_0030);
        wait_ready(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL abort_ready: got timeout, required rx_ready"); end
        clr_pulses = 0;
        cfg_write(6'd32, 32'h0);
        repeat (4) @(negedge clk);
        n_checks++;
        if (clr_pulses != 1) begin n_fail++; $display("FAIL abort_clr_pulses: got %0d, required 1", clr_pulses); end
        n_checks++;
        if (rx_ready_o !== 1'b0) begin n_fail++; $display("FAIL abort_ready_low: got %b, required 0", rx_ready_o); end
        cfg_read(6'd33, rd);
        n_checks++;
        if (rd !== 32'h10) begin n_fail++; $display("FAIL abort_status: got %h, required 00000010", rd); end
        cfg_read(6'd17, rd);
        n_checks++;
        if (rd !== 32'h8000_0030) begin n_fail++; $display("FAIL abort_own: got %h, required 80000030", rd); end
        arm_exp.push_back({12'h210, 16'h0030});
        cfg_write(6'd32, 32'h1);
        wait_ready(ok);
        n_checks++;
        if (!ok || arm_exp.size() != 0) begin
            n_fail++; $display("FAIL abort_rearm: got ok=%b pending=%0d, required ok=1 pending=0", ok, arm_exp.size());
        end
    endtask

    task automatic test_race();
        logic [31:0] rd, e;
        @(negedge clk);
        cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = 6'd17; cfg_data_i = 32'h8000_00AA;
        frame_done_i = 1'b1; frame_len_i = 16'h0008; frame_err_i = 1'b0;
        stat_exp.push_back(32'h0000_0008);
        @(negedge clk);
        cfg_valid_i = 1'b0; frame_done_i = 1'b0;
        cfg_read(6'd17, rd);
        e = stat_exp.pop_front();
        n_checks++;
        if (rd !== e) begin n_fail++; $display("FAIL race_hw_wins: got %h, required %h", rd, e); end
        n_checks++;
        if (head_idx_o !== 2'd2 || rx_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL race_head: got head=%0d ready=%b, required head=2 ready=0", head_idx_o, rx_ready_o);
        end
        // Drop coinciding with a DROP_CNT read leaves exactly one count.
        @(negedge clk);
        cfg_valid_i = 1'b1; cfg_rwn_i = 1'b1; cfg_addr_i = 6'd36;
        frame_done_i = 1'b1; frame_len_i = 16'h0008;
        @(negedge clk);
        cfg_valid_i = 1'b0; cfg_rwn_i = 1'b0; frame_done_i = 1'b0;
        cfg_read(6'd36, rd);
        n_checks++;
        if (rd !== 32'd1) begin n_fail++; $display("FAIL drop_read_race: got %0d, required 1", rd); end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        cfg_write(6'd35, 32'h200);
        @(negedge clk);
        n_checks++;
        if (irq_o !== 1'b1) begin n_fail++; $display("FAIL err_irq: got %b, required 1", irq_o); end
        arm_exp.push_back({12'h220, 16'h0030});
        cfg_write(6'd18, 32'h8000_0030);
        wait_ready(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rstwait_ready: got timeout, required rx_ready"); end
        cfg_addr_i = 6'd33;
        rst_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ch_en_o, ch_clr_o, rx_ready_o, irq_o, head_idx_o, ch_startaddr_o, ch_size_o, cfg_data_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got %h, required 0",
                     {ch_en_o, ch_clr_o, rx_ready_o, irq_o, head_idx_o, ch_startaddr_o, ch_size_o, cfg_data_o});
        end
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_wrap_full();
        test_trunc_err();
        test_coalesce();
        test_timeout();
        test_abort();
        test_race();
        test_reset_mid_wait();
        n_checks++;
        if (arm_exp.size() != 0) begin
            n_fail++; $display("FAIL arm_missing: got %0d unmatched arms, required 0", arm_exp.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
